// File: rtl/pdm_sample_dac.sv
// Sample capture, digital gain and first-order delta-sigma PDM modulator with stall detection.
// Optional dither LFSR is enabled by defining PDM_DITHER_EN.
module pdm_sample_dac #(
  parameter int DATA_W      = 8,
  parameter int GAIN_W      = 8,
  parameter int STALL_LIMIT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [GAIN_W-1:0] gain,
  output logic              sample_ack,
  output logic [DATA_W-1:0] level_out,
  output logic              stall,
  output logic              pdm_out
);

  localparam int CNT_W  = $clog2(STALL_LIMIT + 1);
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   samp_q;
  logic [GAIN_W-1:0]   gain_q;
  logic                ack_q;
  logic [DATA_W-1:0]   level_q;
  logic [DATA_W-1:0]   level_d;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   acc_d;
  logic                pdm_q;
  logic                pdm_d;
  logic                stall_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   mod_in_s;
  logic [PROD_W-1:0]   prod_s;

  // Capture stage: runs regardless of enable so a sample is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      gain_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= sample_valid;
      if (sample_valid) begin
        samp_q <= sample_in;
        gain_q <= gain;
      end
    end
  end

  // Full-width product: (2^DATA_W-1)*2^GAIN_W >> GAIN_W always fits DATA_W.
  assign prod_s  = PROD_W'(samp_q) * (PROD_W'(gain_q) + PROD_W'(1));
  assign level_d = prod_s[GAIN_W +: DATA_W];

  // Scale stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign mod_in_s = (state_q == STALL) ? MIDSCALE : level_q;

`ifdef PDM_DITHER_EN
  logic [15:0]              lfsr_q;
  logic signed [DATA_W+1:0] dsum_s;

  // Galois LFSR x^16+x^14+x^13+x^11+1, frozen while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (state_q == RUN || state_q == STALL) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  // Zero-mean dither: +lfsr[0] -lfsr[1]; negative sums clamp to zero.
  always_comb begin
    dsum_s = $signed({2'b00, acc_q}) + $signed({2'b00, mod_in_s})
           + $signed({{(DATA_W+1){1'b0}}, lfsr_q[0]})
           - $signed({{(DATA_W+1){1'b0}}, lfsr_q[1]});
    acc_d  = '0;
    pdm_d  = 1'b0;
    if (dsum_s[DATA_W+1]) begin
      acc_d = '0;
      pdm_d = 1'b0;
    end else begin
      acc_d = dsum_s[DATA_W-1:0];
      pdm_d = dsum_s[DATA_W];
    end
  end
`else
  logic [DATA_W:0] sum_s;

  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, mod_in_s};
    acc_d = sum_s[DATA_W-1:0];
    pdm_d = sum_s[DATA_W];
  end
`endif

  // Control FSM with registered modulator state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pdm_q   <= 1'b0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pdm_q   <= 1'b0;
      stall_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= RUN;
          acc_q   <= '0;
          pdm_q   <= 1'b0;
          stall_q <= 1'b0;
          cnt_q   <= '0;
        end
        RUN: begin
          acc_q <= acc_d;
          pdm_q <= pdm_d;
          if (sample_valid) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(STALL_LIMIT - 1)) begin
            state_q <= STALL;
            stall_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STALL: begin
          acc_q <= acc_d;
          pdm_q <= pdm_d;
          cnt_q <= '0;
          if (sample_valid) begin
            state_q <= RUN;
            stall_q <= 1'b0;
          end else begin
            stall_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          acc_q   <= '0;
          pdm_q   <= 1'b0;
          stall_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sample_ack = ack_q;
  assign level_out  = mod_in_s;
  assign stall      = stall_q;
  assign pdm_out    = pdm_q;

endmodule

// File: tb/tb_pdm_sample_dac.sv
// Directed, table-driven bench for pdm_sample_dac (default build, no dither).
module tb_pdm_sample_dac;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] gain;
  logic       sample_ack;
  logic [7:0] level_out;
  logic       stall;
  logic       pdm_out;

  int cmp_cnt;
  int err_cnt;

  typedef struct {
    logic [7:0] s;
    logic [7:0] g;
    logic [7:0] lvl;
  } vec_t;

  vec_t vecs[12];

  pdm_sample_dac #(.DATA_W(8), .GAIN_W(8), .STALL_LIMIT(200)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .gain         (gain),
    .sample_ack   (sample_ack),
    .level_out    (level_out),
    .stall        (stall),
    .pdm_out      (pdm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] s, input logic [7:0] g);
    sample_in    = s;
    gain         = g;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  initial begin
    int ones;
    int highs;
    int found;
    int exp_bits[5];

    cmp_cnt = 0;
    err_cnt = 0;
    vecs[0]  = '{s: 8'd200, g: 8'd127, lvl: 8'd100};
    vecs[1]  = '{s: 8'd255, g: 8'd255, lvl: 8'd255};
    vecs[2]  = '{s: 8'd77,  g: 8'd0,   lvl: 8'd0};
    vecs[3]  = '{s: 8'd255, g: 8'd0,   lvl: 8'd0};
    vecs[4]  = '{s: 8'd0,   g: 8'd255, lvl: 8'd0};
    vecs[5]  = '{s: 8'd100, g: 8'd255, lvl: 8'd100};
    vecs[6]  = '{s: 8'd255, g: 8'd127, lvl: 8'd127};
    vecs[7]  = '{s: 8'd10,  g: 8'd3,   lvl: 8'd0};
    vecs[8]  = '{s: 8'd200, g: 8'd63,  lvl: 8'd50};
    vecs[9]  = '{s: 8'd3,   g: 8'd255, lvl: 8'd3};
    vecs[10] = '{s: 8'd64,  g: 8'd191, lvl: 8'd48};
    vecs[11] = '{s: 8'd128, g: 8'd255, lvl: 8'd128};

    rst_n        = 1'b1;
    enable       = 1'b0;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    gain         = 8'd0;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("reset_pdm", int'(pdm_out), 0);
    chk("reset_stall", int'(stall), 0);
    chk("reset_ack", int'(sample_ack), 0);
    chk("reset_level", int'(level_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Midscale sample at unity-ish gain: exact 50% density.
    step();
    enable = 1'b1;
    step();
    strobe(8'd128, 8'd255);
    chk("ack_after_strobe", int'(sample_ack), 1);
    step();
    chk("ack_one_cycle", int'(sample_ack), 0);
    step();
    chk("level_128", int'(level_out), 128);
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (pdm_out) ones++;
    end
    chk("density_128_of_256", ones, 128);

    // Gain scaling table.
    for (int i = 0; i < 12; i++) begin
      strobe(vecs[i].s, vecs[i].g);
      chk($sformatf("vec%0d_ack", i), int'(sample_ack), 1);
      step();
      chk($sformatf("vec%0d_ack_low", i), int'(sample_ack), 0);
      step();
      chk($sformatf("vec%0d_level", i), int'(level_out), int'(vecs[i].lvl));
    end

    // Stall detection: strobes every 100 cycles, then silence.
    for (int k = 0; k < 3; k++) begin
      strobe(8'd40, 8'd255);
      if (k < 2) begin
        for (int i = 0; i < 99; i++) step();
      end
    end
    highs = 0;
    for (int i = 1; i < 200; i++) begin
      step();
      if (stall) highs++;
    end
    chk("stall_not_early", highs, 0);
    step();
    chk("stall_at_limit", int'(stall), 1);
    chk("stall_midscale", int'(level_out), 128);
    strobe(8'd40, 8'd255);
    chk("stall_cleared", int'(stall), 0);
    chk("level_after_stall", int'(level_out), 40);

    // Strobe landing on the exact limit cycle keeps RUN.
    highs = 0;
    for (int i = 0; i < 199; i++) begin
      step();
      if (stall) highs++;
    end
    strobe(8'd40, 8'd255);
    if (stall) highs++;
    for (int i = 0; i < 199; i++) begin
      step();
      if (stall) highs++;
    end
    chk("limit_strobe_no_stall", highs, 0);
    step();
    chk("stall_after_restart", int'(stall), 1);

    // Enable drop and restart with level 64.
    strobe(8'd64, 8'd255);
    step();
    step();
    chk("level_64", int'(level_out), 64);
    enable = 1'b0;
    step();
    chk("disable_pdm0", int'(pdm_out), 0);
    ones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (pdm_out) ones++;
    end
    chk("disable_pdm_stays0", ones, 0);
    enable = 1'b1;
    exp_bits = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("reenable_bit%0d", i), int'(pdm_out), exp_bits[i]);
    end

    // Asynchronous reset while pdm_out is high.
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      if (pdm_out) found = 1;
      else step();
    end
    chk("pdm_high_found", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pdm", int'(pdm_out), 0);
    chk("async_rst_stall", int'(stall), 0);
    chk("async_rst_ack", int'(sample_ack), 0);
    chk("async_rst_level", int'(level_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pdm_out) ones++;
    end
    chk("post_rst_pdm0", ones, 0);
    chk("post_rst_level", int'(level_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
